// File: rtl/prot_debnc_pkg.sv
// prot_debnc_pkg: shared constants, prescaler-select encoding, channel
// indices and a small helper for the debounce filter.
// Optional sticky-flag feature is enabled with the macro PROT_STICKY_EN.
package prot_debnc_pkg;

    localparam int DBC_W    = 4;      // debounce count width
    localparam int PSEL_W   = 2;      // prescaler select width
    localparam int PRE_WRAP = 24000;  // slow prescaler wraps here
    localparam int PRE_W    = 15;     // slow prescaler width
    localparam int NTICK    = 4;      // number of selectable tick strobes

    typedef enum logic [PSEL_W-1:0] {
        PSEL_X1   = 2'd0,
        PSEL_X8   = 2'd1,
        PSEL_X24  = 2'd2,
        PSEL_X24K = 2'd3
    } psel_e;

    // Channel assignment of the protection flags
    localparam int CH_UVP      = 0;
    localparam int CH_OCP      = 1;
    localparam int CH_OVP      = 2;
    localparam int CH_OTPI_CF  = 3;
    localparam int CH_SCP      = 4;
    localparam int CH_V5OCP    = 5;
    localparam int CH_CDOVP    = 6;
    localparam int CH_DN_FAULT = 7;
    localparam int CH_LDBUVP   = 8;
    localparam int CH_LDBOCP   = 9;

    // A programmed count of 0 behaves exactly like 1
    function automatic logic [DBC_W-1:0] eff_dbc(input logic [DBC_W-1:0] dbc);
        return (dbc == '0) ? DBC_W'(1) : dbc;
    endfunction

endpackage

// File: rtl/prot_debnc_if.sv
// prot_debnc_if: bundles the raw flags, per-channel configuration and the
// debounced outputs. With PROT_STICKY_EN defined it also carries the
// write-1-to-clear strobes and the sticky flags.
interface prot_debnc_if
    import prot_debnc_pkg::*;
#(
    parameter int NCH = 10
);
    logic [NCH-1:0]        i_raw;
    logic [DBC_W*NCH-1:0]  i_dbc;
    logic [PSEL_W*NCH-1:0] i_psel;
    logic [NCH-1:0]        o_deb;
    logic [NCH-1:0]        o_chg;
`ifdef PROT_STICKY_EN
    logic [NCH-1:0]        i_clr;
    logic [NCH-1:0]        o_stk;

    modport master (output i_raw, i_dbc, i_psel, i_clr, input o_deb, o_chg, o_stk);
    modport slave  (input i_raw, i_dbc, i_psel, i_clr, output o_deb, o_chg, o_stk);
`else
    modport master (output i_raw, i_dbc, i_psel, input o_deb, o_chg);
    modport slave  (input i_raw, i_dbc, i_psel, output o_deb, o_chg);
`endif
endinterface

// File: rtl/prot_debnc_ch.sv
// prot_debnc_ch: one debounce channel. Two-flop synchroniser, stable-time
// counter advanced on the selected prescaler tick, config-change restart,
// debounced level with a one-clock change pulse.
// With PROT_STICKY_EN defined, a sticky flag records rising edges of o_deb.
module prot_debnc_ch
    import prot_debnc_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rstz,
    input  logic              i_raw,
    input  logic [DBC_W-1:0]  i_dbc,
    input  logic [PSEL_W-1:0] i_psel,
    input  logic [NTICK-1:0]  i_ticks,
`ifdef PROT_STICKY_EN
    input  logic              i_clr,
    output logic              o_stk,
`endif
    output logic              o_deb,
    output logic              o_chg
);

    logic              r_s1;
    logic              r_s2;
    logic              r_deb;
    logic              r_chg;
    logic [DBC_W-1:0]  r_cnt;
    logic [DBC_W-1:0]  r_dbc;
    logic [PSEL_W-1:0] r_psel;

    logic              w_tick;
    logic              w_diff;
    logic              w_cfg_chg;
    logic              w_done;
    logic              w_fire;
    logic [DBC_W:0]    w_cnt_inc;

    // Pick the prescaler strobe this channel counts on
    always_comb begin
        w_tick = 1'b0;
        case (psel_e'(r_psel))
            PSEL_X1:   w_tick = i_ticks[0];
            PSEL_X8:   w_tick = i_ticks[1];
            PSEL_X24:  w_tick = i_ticks[2];
            PSEL_X24K: w_tick = i_ticks[3];
            default:   w_tick = 1'b0;
        endcase
    end

    assign w_diff    = (r_s2 != r_deb);
    assign w_cfg_chg = (i_dbc != r_dbc) || (i_psel != r_psel);
    assign w_cnt_inc = {1'b0, r_cnt} + (DBC_W+1)'(1);
    assign w_done    = (w_cnt_inc >= {1'b0, eff_dbc(r_dbc)});
    // Comparing s with o_deb first means a level that returns on the
    // completing tick never toggles.
    assign w_fire    = w_diff && !w_cfg_chg && w_tick && w_done;

    // Synchroniser, config shadow, stable-time counter and debounced level
    always_ff @(posedge i_clk) begin
        if (!i_rstz) begin
            r_s1   <= RST_BIT;
            r_s2   <= RST_BIT;
            r_deb  <= RST_BIT;
            r_chg  <= 1'b0;
            r_cnt  <= '0;
            r_dbc  <= '0;
            r_psel <= '0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_dbc  <= i_dbc;
            r_psel <= i_psel;
            r_chg  <= 1'b0;
            if (!w_diff || w_cfg_chg) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (w_fire) begin
                    r_deb <= r_s2;
                    r_chg <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc[DBC_W-1:0];
                end
            end
        end
    end

    assign o_deb = r_deb;
    assign o_chg = r_chg;

`ifdef PROT_STICKY_EN
    logic r_stk;

    // Sticky flag: set on a rising debounced edge, set beats clear
    always_ff @(posedge i_clk) begin
        if (!i_rstz) begin
            r_stk <= 1'b0;
        end else if (w_fire && r_s2) begin
            r_stk <= 1'b1;
        end else if (i_clr) begin
            r_stk <= 1'b0;
        end
    end

    assign o_stk = r_stk;
`endif

endmodule

// File: rtl/prot_debnc.sv
// prot_debnc: multi-channel debounce filter for the analog protection flags.
// Holds the shared free-running prescaler and NCH independent channels.
// Optional sticky flags (i_clr/o_stk) are built when PROT_STICKY_EN is defined.
module prot_debnc
    import prot_debnc_pkg::*;
#(
    parameter int             NCH     = 10,
    parameter logic [NCH-1:0] RST_VAL = '0
) (
    input  logic        i_clk,
    input  logic        i_rstz,
    prot_debnc_if.slave io_bus
);

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_c8;
    logic [4:0]       r_c24;
    logic [NTICK-1:0] w_ticks;
    logic [NCH-1:0]   w_deb;
    logic [NCH-1:0]   w_chg;

    // Free-running prescaler; the x8/x24 strobes use their own small counters
    always_ff @(posedge i_clk) begin
        if (!i_rstz) begin
            r_pre <= '0;
            r_c8  <= '0;
            r_c24 <= '0;
        end else begin
            r_pre <= (r_pre == PRE_W'(PRE_WRAP - 1)) ? '0 : r_pre + PRE_W'(1);
            r_c8  <= r_c8 + 3'd1;
            r_c24 <= (r_c24 == 5'd23) ? 5'd0 : r_c24 + 5'd1;
        end
    end

    // Bit order follows the prescaler-select encoding
    assign w_ticks = {(r_pre == '0), (r_c24 == '0), (r_c8 == '0), 1'b1};

`ifdef PROT_STICKY_EN
    logic [NCH-1:0] w_stk;
    assign io_bus.o_stk = w_stk;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            prot_debnc_ch #(
                .RST_BIT (RST_VAL[gi])
            ) u_ch (
                .i_clk   (i_clk),
                .i_rstz  (i_rstz),
                .i_raw   (io_bus.i_raw[gi]),
                .i_dbc   (io_bus.i_dbc[gi*DBC_W +: DBC_W]),
                .i_psel  (io_bus.i_psel[gi*PSEL_W +: PSEL_W]),
                .i_ticks (w_ticks),
`ifdef PROT_STICKY_EN
                .i_clr   (io_bus.i_clr[gi]),
                .o_stk   (w_stk[gi]),
`endif
                .o_deb   (w_deb[gi]),
                .o_chg   (w_chg[gi])
            );
        end
    endgenerate

    assign io_bus.o_deb = w_deb;
    assign io_bus.o_chg = w_chg;

endmodule
